// File: rtl/reg_map_pkg.sv
// Shared register-map definitions for the register access arbiter:
// read-only constant addresses/values, FSM and port enums, and the
// address classification helpers.
package reg_map_pkg;

  // Read-only identification / capability registers
  localparam logic [7:0] ADDR_DEVICE_ID   = 8'h00;
  localparam logic [7:0] ADDR_VERSION_MAJ = 8'h01;
  localparam logic [7:0] ADDR_VERSION_MIN = 8'h02;
  localparam logic [7:0] ADDR_LINK_CAPS   = 8'h03;
  localparam logic [7:0] ADDR_DATA_CLK    = 8'h04;

  localparam logic [7:0] VAL_DEVICE_ID    = 8'hA7;
  localparam logic [7:0] VAL_VERSION_MAJ  = 8'h01;
  localparam logic [7:0] VAL_VERSION_MIN  = 8'h00;
  localparam logic [7:0] VAL_LINK_CAPS    = 8'h15;
  localparam logic [7:0] VAL_DATA_CLK     = 8'h04;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef enum logic {PORT_I2C, PORT_SPI} port_t;

  typedef enum logic [1:0] {CLS_UNMAPPED, CLS_RO, CLS_RW} reg_class_t;

  // Address falls inside the writable control window
  function automatic logic is_writable_reg(input logic [7:0] addr,
                                           input logic [7:0] rw_base,
                                           input logic [7:0] rw_last);
    return (addr >= rw_base) && (addr <= rw_last);
  endfunction

  // Address is one of the read-only constants
  function automatic logic is_readonly_reg(input logic [7:0] addr);
    logic hit;
    case (addr)
      ADDR_DEVICE_ID, ADDR_VERSION_MAJ, ADDR_VERSION_MIN,
      ADDR_LINK_CAPS, ADDR_DATA_CLK: hit = 1'b1;
      default:                        hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Constant value returned for a read-only address (0 elsewhere)
  function automatic logic [7:0] ro_value(input logic [7:0] addr);
    logic [7:0] val;
    case (addr)
      ADDR_DEVICE_ID:   val = VAL_DEVICE_ID;
      ADDR_VERSION_MAJ: val = VAL_VERSION_MAJ;
      ADDR_VERSION_MIN: val = VAL_VERSION_MIN;
      ADDR_LINK_CAPS:   val = VAL_LINK_CAPS;
      ADDR_DATA_CLK:    val = VAL_DATA_CLK;
      default:          val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/reg_access_arbiter_rr_arb2.sv
// Two-way round-robin grant. Grants are combinational from the requests;
// the last winner is remembered so that a tie goes to the other port.
module rr_arb2
  import reg_map_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic req_i2c,
  input  logic req_spi,
  output logic gnt_i2c,
  output logic gnt_spi
);

  port_t last_grant_reg;

  // Grant a lone requester, or on a tie the port that did not win last
  always_comb begin
    gnt_i2c = enable && req_i2c && (!req_spi || (last_grant_reg == PORT_SPI));
    gnt_spi = enable && req_spi && (!req_i2c || (last_grant_reg == PORT_I2C));
  end

  // Remember the winner; SPI after reset so I2C takes the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= PORT_SPI;
    end else if (gnt_i2c) begin
      last_grant_reg <= PORT_I2C;
    end else if (gnt_spi) begin
      last_grant_reg <= PORT_SPI;
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares one register file between the I2C and SPI request channels.
// One access in flight: IDLE (grant) -> ACCESS (register-file strobe)
// -> RESP (one-cycle response to the winner). The register map splits
// into read-only constants, a writable window and unmapped space.
module reg_access_arbiter
  import reg_map_pkg::*;
#(
  parameter logic [7:0] RW_BASE = 8'h10,
  parameter logic [7:0] RW_LAST = 8'h1F,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i2c_req_valid,
  output logic             i2c_req_ready,
  input  logic             i2c_req_we,
  input  logic [7:0]       i2c_req_addr,
  input  logic [7:0]       i2c_req_wdata,
  output logic             i2c_rsp_valid,
  output logic [7:0]       i2c_rsp_rdata,
  output logic             i2c_rsp_err,
  input  logic             spi_req_valid,
  output logic             spi_req_ready,
  input  logic             spi_req_we,
  input  logic [7:0]       spi_req_addr,
  input  logic [7:0]       spi_req_wdata,
  output logic             spi_rsp_valid,
  output logic [7:0]       spi_rsp_rdata,
  output logic             spi_rsp_err,
  output logic             rf_en,
  output logic             rf_we,
  output logic [7:0]       rf_addr,
  output logic [7:0]       rf_wdata,
  input  logic [7:0]       rf_rdata,
  output logic [CNT_W-1:0] contention_count,
  output logic             busy
);

  state_t           state_reg;
  port_t            lat_port_reg;
  logic             lat_we_reg;
  logic [7:0]       lat_addr_reg;
  reg_class_t       lat_class_reg;

  logic             rf_en_reg;
  logic             rf_we_reg;
  logic [7:0]       rf_addr_reg;
  logic [7:0]       rf_wdata_reg;

  logic [1:0]       rsp_valid_reg;
  logic             rsp_err_reg;
  logic [7:0]       rsp_data_reg;
  logic             rsp_use_rf_reg;

  logic [CNT_W-1:0] cnt_reg;

  logic             idle;
  logic             gnt_i2c;
  logic             gnt_spi;
  logic             win_any;
  logic             win_we;
  logic [7:0]       win_addr;
  logic [7:0]       win_wdata;
  reg_class_t       win_class;
  logic [7:0]       rsp_rdata_mux;
  logic [7:0]       rsp_rdata_w [2];
  logic [1:0]       rsp_err_w;

  assign idle = (state_reg == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .enable  (idle),
    .req_i2c (i2c_req_valid),
    .req_spi (spi_req_valid),
    .gnt_i2c (gnt_i2c),
    .gnt_spi (gnt_spi)
  );

  // Winner's payload and its register-map class
  always_comb begin
    win_any   = gnt_i2c || gnt_spi;
    win_we    = gnt_i2c ? i2c_req_we    : spi_req_we;
    win_addr  = gnt_i2c ? i2c_req_addr  : spi_req_addr;
    win_wdata = gnt_i2c ? i2c_req_wdata : spi_req_wdata;
    if (is_writable_reg(win_addr, RW_BASE, RW_LAST)) begin
      win_class = CLS_RW;
    end else if (is_readonly_reg(win_addr)) begin
      win_class = CLS_RO;
    end else begin
      win_class = CLS_UNMAPPED;
    end
  end

  // Main FSM: latch the grant, strobe the register file, pulse the response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      lat_port_reg   <= PORT_I2C;
      lat_we_reg     <= 1'b0;
      lat_addr_reg   <= 8'h00;
      lat_class_reg  <= CLS_UNMAPPED;
      rf_en_reg      <= 1'b0;
      rf_we_reg      <= 1'b0;
      rf_addr_reg    <= 8'h00;
      rf_wdata_reg   <= 8'h00;
      rsp_valid_reg  <= 2'b00;
      rsp_err_reg    <= 1'b0;
      rsp_data_reg   <= 8'h00;
      rsp_use_rf_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_any) begin
            state_reg     <= ACCESS;
            lat_port_reg  <= gnt_i2c ? PORT_I2C : PORT_SPI;
            lat_we_reg    <= win_we;
            lat_addr_reg  <= win_addr;
            lat_class_reg <= win_class;
            // Only the writable window ever reaches the register file
            rf_en_reg     <= (win_class == CLS_RW);
            rf_we_reg     <= (win_class == CLS_RW) && win_we;
            rf_addr_reg   <= (win_class == CLS_RW) ? win_addr : 8'h00;
            rf_wdata_reg  <= ((win_class == CLS_RW) && win_we) ? win_wdata : 8'h00;
          end
        end
        ACCESS: begin
          state_reg      <= RESP;
          rf_en_reg      <= 1'b0;
          rf_we_reg      <= 1'b0;
          rf_addr_reg    <= 8'h00;
          rf_wdata_reg   <= 8'h00;
          rsp_valid_reg  <= (lat_port_reg == PORT_SPI) ? 2'b10 : 2'b01;
          rsp_err_reg    <= (lat_class_reg == CLS_UNMAPPED) ||
                            ((lat_class_reg == CLS_RO) && lat_we_reg);
          rsp_data_reg   <= ((lat_class_reg == CLS_RO) && !lat_we_reg) ?
                            ro_value(lat_addr_reg) : 8'h00;
          // Register-file read data arrives during RESP, so it is muxed live
          rsp_use_rf_reg <= (lat_class_reg == CLS_RW) && !lat_we_reg;
        end
        RESP: begin
          state_reg      <= IDLE;
          rsp_valid_reg  <= 2'b00;
          rsp_err_reg    <= 1'b0;
          rsp_data_reg   <= 8'h00;
          rsp_use_rf_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Saturating count of IDLE cycles in which both ports were requesting
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (idle && i2c_req_valid && spi_req_valid && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign rsp_rdata_mux = rsp_use_rf_reg ? rf_rdata : rsp_data_reg;

  // Response data/err are forced to zero unless that port's pulse is high
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign rsp_rdata_w[gi] = rsp_valid_reg[gi] ? rsp_rdata_mux : 8'h00;
    assign rsp_err_w[gi]   = rsp_valid_reg[gi] & rsp_err_reg;
  end

  assign i2c_req_ready    = gnt_i2c;
  assign spi_req_ready    = gnt_spi;
  assign i2c_rsp_valid    = rsp_valid_reg[0];
  assign i2c_rsp_rdata    = rsp_rdata_w[0];
  assign i2c_rsp_err      = rsp_err_w[0];
  assign spi_rsp_valid    = rsp_valid_reg[1];
  assign spi_rsp_rdata    = rsp_rdata_w[1];
  assign spi_rsp_err      = rsp_err_w[1];
  assign rf_en            = rf_en_reg;
  assign rf_we            = rf_we_reg;
  assign rf_addr          = rf_addr_reg;
  assign rf_wdata         = rf_wdata_reg;
  assign contention_count = cnt_reg;
  assign busy             = !idle;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: directed vector table, round-robin and
// reset-abort sequences, then random dual-port traffic, all observed by a
// transaction-level reference model evaluated once per cycle.
module tb_reg_access_arbiter;
  import reg_map_pkg::*;

  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i2c_req_valid = 1'b0, i2c_req_we = 1'b0;
  logic [7:0]    i2c_req_addr = 8'h00, i2c_req_wdata = 8'h00;
  logic          spi_req_valid = 1'b0, spi_req_we = 1'b0;
  logic [7:0]    spi_req_addr = 8'h00, spi_req_wdata = 8'h00;
  logic          i2c_req_ready, i2c_rsp_valid, i2c_rsp_err;
  logic [7:0]    i2c_rsp_rdata;
  logic          spi_req_ready, spi_rsp_valid, spi_rsp_err;
  logic [7:0]    spi_rsp_rdata;
  logic          rf_en, rf_we;
  logic [7:0]    rf_addr, rf_wdata, rf_rdata;
  logic [CW-1:0] contention_count;
  logic          busy;

  logic [7:0]    rf_mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_access_arbiter #(.RW_BASE(8'h10), .RW_LAST(8'h1F), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i2c_req_valid(i2c_req_valid), .i2c_req_ready(i2c_req_ready),
    .i2c_req_we(i2c_req_we), .i2c_req_addr(i2c_req_addr), .i2c_req_wdata(i2c_req_wdata),
    .i2c_rsp_valid(i2c_rsp_valid), .i2c_rsp_rdata(i2c_rsp_rdata), .i2c_rsp_err(i2c_rsp_err),
    .spi_req_valid(spi_req_valid), .spi_req_ready(spi_req_ready),
    .spi_req_we(spi_req_we), .spi_req_addr(spi_req_addr), .spi_req_wdata(spi_req_wdata),
    .spi_rsp_valid(spi_rsp_valid), .spi_rsp_rdata(spi_rsp_rdata), .spi_rsp_err(spi_rsp_err),
    .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .contention_count(contention_count), .busy(busy)
  );

  // Register file: registered read, cleared while the bench holds reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) rf_mem[i] <= 8'h00;
      rf_rdata <= 8'h00;
    end else if (rf_en) begin
      rf_rdata <= rf_mem[rf_addr];
      if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    end
  end

  // ---------------- reference model state ----------------
  logic [7:0] ro_tab [5] = '{8'hA7, 8'h01, 8'h00, 8'h15, 8'h04};
  logic [7:0] shadow [256];
  int         cyc = 0;
  bit         m_have = 0;
  int         m_g = 0;
  bit         m_port = 0;
  bit         m_we = 0;
  logic [7:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  bit         m_err = 0;
  bit         m_last = 1;
  int         m_cont = 0;
  bit         hs [2];
  int         rsp_cnt [2];
  logic [7:0] last_rdata [2];
  bit         last_err [2];
  bit         glog [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit in_window(input logic [7:0] a);
    return (a >= 8'h10) && (a <= 8'h1F);
  endfunction

  // One cycle of the model: compare outputs, then account for a new grant
  task automatic mon();
    bit idle, bi, bs, e_ri, e_rs, e_en, resp_now, e_vi, e_vs, p;
    cyc++;
    if (rst) begin
      m_have = 0; m_last = 1; m_cont = 0;
      hs[0] = 0; hs[1] = 0;
      for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
      return;
    end
    idle = !m_have || (cyc >= m_g + 3);
    bi = i2c_req_valid;
    bs = spi_req_valid;
    e_ri = idle && bi && (!bs || m_last == 1'b1);
    e_rs = idle && bs && (!bi || m_last == 1'b0);
    chk("i2c_ready", 32'(i2c_req_ready), 32'(e_ri));
    chk("spi_ready", 32'(spi_req_ready), 32'(e_rs));
    chk("busy", 32'(busy), 32'(!idle));
    chk("contention", 32'(contention_count), 32'(m_cont));
    if (idle && bi && bs && m_cont != CNTMAX) m_cont++;

    if (m_have && cyc == m_g + 1) begin
      e_en = in_window(m_addr);
      chk("rf_en", 32'(rf_en), 32'(e_en));
      chk("rf_we", 32'(rf_we), 32'(e_en && m_we));
      if (e_en) chk("rf_addr", 32'(rf_addr), 32'(m_addr));
      if (e_en && m_we) chk("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
    end else begin
      chk("rf_en_idle", 32'(rf_en), 0);
      chk("rf_we_idle", 32'(rf_we), 0);
    end

    resp_now = m_have && (cyc == m_g + 2);
    e_vi = resp_now && (m_port == 1'b0);
    e_vs = resp_now && (m_port == 1'b1);
    chk("i2c_rsp_valid", 32'(i2c_rsp_valid), 32'(e_vi));
    chk("i2c_rsp_rdata", 32'(i2c_rsp_rdata), e_vi ? 32'(m_rdata) : 0);
    chk("i2c_rsp_err",   32'(i2c_rsp_err),   e_vi ? 32'(m_err) : 0);
    chk("spi_rsp_valid", 32'(spi_rsp_valid), 32'(e_vs));
    chk("spi_rsp_rdata", 32'(spi_rsp_rdata), e_vs ? 32'(m_rdata) : 0);
    chk("spi_rsp_err",   32'(spi_rsp_err),   e_vs ? 32'(m_err) : 0);
    if (i2c_rsp_valid) begin
      rsp_cnt[0]++; last_rdata[0] = i2c_rsp_rdata; last_err[0] = i2c_rsp_err;
      $display("txn i2c we=%0d addr=%h rdata=%h err=%0d", m_we, m_addr, i2c_rsp_rdata, i2c_rsp_err);
    end
    if (spi_rsp_valid) begin
      rsp_cnt[1]++; last_rdata[1] = spi_rsp_rdata; last_err[1] = spi_rsp_err;
      $display("txn spi we=%0d addr=%h rdata=%h err=%0d", m_we, m_addr, spi_rsp_rdata, spi_rsp_err);
    end

    hs[0] = i2c_req_ready;
    hs[1] = spi_req_ready;
    if (i2c_req_ready) glog.push_back(1'b0);
    else if (spi_req_ready) glog.push_back(1'b1);

    if (e_ri || e_rs) begin
      p = e_rs;
      m_have = 1; m_g = cyc; m_port = p; m_last = p;
      m_we    = p ? spi_req_we    : i2c_req_we;
      m_addr  = p ? spi_req_addr  : i2c_req_addr;
      m_wdata = p ? spi_req_wdata : i2c_req_wdata;
      if (in_window(m_addr)) begin
        m_err = 0;
        if (m_we) begin shadow[m_addr] = m_wdata; m_rdata = 8'h00; end
        else m_rdata = shadow[m_addr];
      end else if (m_addr <= 8'h04) begin
        m_err   = m_we;
        m_rdata = m_we ? 8'h00 : ro_tab[m_addr];
      end else begin
        m_err = 1; m_rdata = 8'h00;
      end
    end
  endtask

  // Evaluate at the falling edge, then return just after the rising edge
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input bit v, input bit we,
                         input logic [7:0] addr, input logic [7:0] wd);
    if (port) begin
      spi_req_valid = v; spi_req_we = we; spi_req_addr = addr; spi_req_wdata = wd;
    end else begin
      i2c_req_valid = v; i2c_req_we = we; i2c_req_addr = addr; i2c_req_wdata = wd;
    end
  endtask

  // Single-port transaction with bounded waits on ready and response
  task automatic do_req(input bit port, input bit we, input logic [7:0] addr,
                        input logic [7:0] wd, output bit ok,
                        output logic [7:0] rdata, output bit err);
    int n0;
    ok = 0; rdata = 8'h00; err = 0;
    n0 = rsp_cnt[port];
    set_req(port, 1'b1, we, addr, wd);
    for (int k = 0; k < 40; k++) begin
      step();
      if (hs[port]) break;
    end
    set_req(port, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) begin
      if (rsp_cnt[port] != n0) break;
      step();
    end
    if (rsp_cnt[port] != n0) begin
      ok = 1; rdata = last_rdata[port]; err = last_err[port];
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] agg;
    agg = {i2c_req_ready, spi_req_ready, i2c_rsp_valid, spi_rsp_valid,
           i2c_rsp_err, spi_rsp_err, rf_en, rf_we, busy, 23'd0};
    chk({tag, "_ctrl"}, agg, 0);
    chk({tag, "_data"}, {i2c_rsp_rdata, spi_rsp_rdata, rf_addr, rf_wdata}, 0);
    chk({tag, "_cnt"}, 32'(contention_count), 0);
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 8'($urandom_range(0, 5));
      1: return 8'($urandom_range(8'h0E, 8'h21));
      2: return 8'(8'h10 + $urandom_range(0, 3));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    bit         exp_err;
  } vec_t;

  vec_t vecs [18];

  initial begin
    bit ok, err;
    logic [7:0] rd;
    int g0, n0;

    vecs[0]  = '{0, 0, 8'h00, 8'h00, 8'hA7, 0};
    vecs[1]  = '{1, 1, 8'h12, 8'h5A, 8'h00, 0};
    vecs[2]  = '{1, 0, 8'h12, 8'h00, 8'h5A, 0};
    vecs[3]  = '{0, 1, 8'h01, 8'hFF, 8'h00, 1};
    vecs[4]  = '{0, 0, 8'h01, 8'h00, 8'h01, 0};
    vecs[5]  = '{1, 0, 8'h80, 8'h00, 8'h00, 1};
    vecs[6]  = '{1, 1, 8'h80, 8'h11, 8'h00, 1};
    vecs[7]  = '{0, 0, 8'h04, 8'h00, 8'h04, 0};
    vecs[8]  = '{0, 0, 8'h03, 8'h00, 8'h15, 0};
    vecs[9]  = '{1, 0, 8'h02, 8'h00, 8'h00, 0};
    vecs[10] = '{0, 1, 8'h1F, 8'hC3, 8'h00, 0};
    vecs[11] = '{1, 0, 8'h1F, 8'h00, 8'hC3, 0};
    vecs[12] = '{0, 0, 8'h05, 8'h00, 8'h00, 1};
    vecs[13] = '{1, 1, 8'h10, 8'h9E, 8'h00, 0};
    vecs[14] = '{0, 0, 8'h10, 8'h00, 8'h9E, 0};
    vecs[15] = '{0, 0, 8'h0F, 8'h00, 8'h00, 1};
    vecs[16] = '{1, 1, 8'h20, 8'h44, 8'h00, 1};
    vecs[17] = '{1, 1, 8'h00, 8'h55, 8'h00, 1};

    step(); step(); step();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      do_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, ok, rd, err);
      chk($sformatf("vec%0d_done", i), 32'(ok), 1);
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
    end

    // Continuous dual requests from reset: strict alternation starting with I2C
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    g0 = glog.size();
    set_req(0, 1'b1, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h03, 8'h00);
    for (int k = 0; k < 60; k++) begin
      step();
      if (glog.size() >= g0 + 6) break;
    end
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("rr_six_grants", 32'(glog.size() >= g0 + 6), 1);
    if (glog.size() >= g0 + 6) begin
      for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), 32'(glog[g0 + k]), 32'(k % 2));
    end
    step(); step(); step();
    chk("rr_contention", 32'(contention_count), 6);

    // Random traffic on both ports
    for (int c = 0; c < 600; c++) begin
      step();
      if (hs[0]) i2c_req_valid = 1'b0;
      if (hs[1]) spi_req_valid = 1'b0;
      if (!i2c_req_valid && $urandom_range(0, 2) == 0)
        set_req(0, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
      if (!spi_req_valid && $urandom_range(0, 2) == 0)
        set_req(1, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
    end
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(); step(); step(); step();

    // Reset during ACCESS of a writable write: no response, strobes drop
    n0 = rsp_cnt[1];
    set_req(1, 1'b1, 1'b1, 8'h15, 8'h33);
    for (int k = 0; k < 10; k++) begin
      step();
      if (hs[1]) break;
    end
    chk("abort_granted", 32'(hs[1]), 1);
    chk("abort_rf_we_access", 32'(rf_we), 1);
    rst = 1'b1;
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    @(negedge clk);
    check_all_zero("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("abort_no_rsp", 32'(rsp_cnt[1]), 32'(n0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares the single 256x8 register file between the I2C slave front-end and the SPI command channel.
- Round-robin arbitration, one access in flight.
- Enforces the register map: read-only ID/version/capability constants, a writable control window, and unmapped-address errors.
- Returns per-requester response pulses. The scoreboard's golden model is the reference this block's visible behaviour must match.

Parameters:
- RW_BASE, 8'h10, first writable address.
- RW_LAST, 8'h1F, last writable address (inclusive).
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i2c_req_valid  in  1  I2C request pending
- i2c_req_ready  out  1  I2C request accepted this cycle
- i2c_req_we  in  1  1=write, 0=read
- i2c_req_addr  in  8  register address
- i2c_req_wdata  in  8  write data
- i2c_rsp_valid  out  1  one-cycle response pulse
- i2c_rsp_rdata  out  8  read data (0x00 for writes)
- i2c_rsp_err  out  1  RO-write or unmapped access
- spi_req_valid, spi_req_ready, spi_req_we, spi_req_addr, spi_req_wdata, spi_rsp_valid, spi_rsp_rdata, spi_rsp_err: same directions, widths and meaning, SPI side
- rf_en  out  1  register-file access strobe
- rf_we  out  1  register-file write enable
- rf_addr  out  8  register-file address
- rf_wdata  out  8  register-file write data
- rf_rdata  in  8  register-file read data, valid the cycle after rf_en
- contention_count  out  CNT_W  saturating count of cycles where both valid were high in IDLE
- busy  out  1  FSM not in IDLE

Behaviour:
Reset:
- After reset, all outputs are 0.
- FSM goes to IDLE; last_grant is set to SPI, so I2C wins the first tie.
- Reset asserted mid-operation aborts the transaction at the next edge: no rsp_valid is produced and rf_en/rf_we drop.

FSM, IDLE -> ACCESS -> RESP -> IDLE:
- IDLE:
  - If exactly one valid is high, grant it.
  - If both are high, grant the port that is not last_grant.
  - The winner's req_ready is high combinationally in this cycle. we/addr/wdata are latched and last_grant is updated.
  - The loser's ready stays 0; it must hold valid and its payload stable.
- ACCESS: address classification:
  - Read-only constants: 0x00=0xA7, 0x01=0x01, 0x02=0x00, 0x03=0x15, 0x04=0x04.
  - Writable: RW_BASE..RW_LAST.
  - Unmapped: everything else.
- ACCESS actions by class:
  - Writable read: rf_en=1, rf_we=0.
  - Writable write: rf_en=1, rf_we=1, rf_wdata = latched data.
  - RO read: rf_en=0; data is taken from the constant.
  - RO write or unmapped access: rf_en=0, err latched.
- RESP:
  - Exactly one rsp_valid pulse goes to the granted port.
  - rdata: rf_rdata for a writable read, the constant for an RO read, 0x00 otherwise.
  - err=1 for an RO write or any unmapped access.
  - The non-granted port's rsp signals stay 0. Next state is IDLE.
- rsp_rdata/rsp_err are valid only while rsp_valid is high; hold 0 otherwise.

Timing and handshake:
- Latency: handshake in cycle N gives rsp_valid in cycle N+2.
- Peak throughput is one transaction per 3 cycles; there is no pipelining.
- There is no response backpressure; requesters must capture the pulse.

Fairness and counters:
- Under continuous dual requests, grants strictly alternate, so neither port waits more than one transaction.
- contention_count increments each IDLE cycle with both valid high, and saturates at all-ones.
- busy = (state != IDLE).

Edge cases:
- A write to an RO address never reaches the register file.
- A valid that rises during ACCESS/RESP is only considered in the next IDLE.
- After a RESP, a same-port request issued back-to-back is accepted in the very next IDLE cycle.

Decomposition:
- Shared package reg_map_pkg contains:
  - ADDR_DEVICE_ID/VERSION_MAJ/VERSION_MIN/LINK_CAPS/DATA_CLK and their constant values.
  - A state enum {IDLE, ACCESS, RESP}.
  - A port-id enum {PORT_I2C, PORT_SPI}.
  - Functions is_writable_reg, is_readonly_reg and ro_value.
- The scoreboard bench package imports the same constants.
- One natural sub-module: rr_arb2, a two-way round-robin grant with last_grant state.

Test Plan:
- Reset, then an I2C read of 0x00 -> rsp_valid at N+2, rdata=0xA7, err=0, rf_en never high.
- SPI write 0x12<=0x5A, then SPI read 0x12 -> rf_we pulse with addr 0x12 and data 0x5A; the read returns 0x5A, err=0.
- I2C write 0x01<=0xFF -> err=1, no rf_we; a following read of 0x01 returns 0x01.
- Both valid held high for 6 transactions from reset -> grant order I2C, SPI, I2C, SPI, I2C, SPI; contention_count is non-zero and counts each IDLE cycle where both were high.
- Read of unmapped 0x80 -> rdata=0x00, err=1; a write of 0x80 gives err=1 with no rf_we.
- rst pulsed during ACCESS of a pending write 0x15<=0x33 -> no rsp_valid; rf_we is low from the next edge; all outputs are 0.
